char_plane_write_scheduler: RTL and testbench

//  Shares the text-mode character plane's single write port between two character sources (e.g. UART feeder, keypad).
//  - Arbitrates round-robin; handshake is valid/ready.
//  - Interprets control codes and maintains the cursor.
//  - Runs a full-screen clear sweep.
//  - Sits between the character sources and the character plane; the pixel encoder reads the plane independently.

---
 rtl/char_plane_write_scheduler_pkg.sv | 23 ++
 rtl/char_plane_write_scheduler_rr_arbiter2.sv | 23 ++
 rtl/char_plane_write_scheduler.sv | 152 +++++++++++++++
 tb/tb_char_plane_write_scheduler.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/char_plane_write_scheduler_pkg.sv
// char_sched_pkg: state encoding, character codes and a printable-range
// helper shared by the character plane write scheduler.
package char_sched_pkg;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_WRITE = 2'd1,
      S_CLEAR = 2'd2
   } state_t;

   localparam logic [7:0] CH_SPACE     = 8'h20;
   localparam logic [7:0] CH_BS        = 8'h08;
   localparam logic [7:0] CH_LF        = 8'h0A;
   localparam logic [7:0] CH_CR        = 8'h0D;
   localparam logic [7:0] CH_FF        = 8'h0C;
   localparam logic [7:0] CH_MAX_PRINT = 8'h7E;

   // True for characters that occupy a cell (space through tilde).
   function automatic logic is_printable(input logic [7:0] c);
      return (c >= CH_SPACE) && (c <= CH_MAX_PRINT);
   endfunction

endpackage

// File: rtl/char_plane_write_scheduler_rr_arbiter2.sv
// rr_arbiter2: two-way round-robin select. A lone valid requester wins;
// when both are valid the one that did not win last time is chosen.
// ready is one-hot or zero and is gated by enable.
module rr_arbiter2 (
   input  logic [1:0] valid,
   input  logic       last_grant,
   input  logic       enable,
   output logic [1:0] ready,
   output logic       sel
);

   // Pick the requester and qualify its ready with enable.
   always_comb begin
      sel = ~last_grant;
      if (valid == 2'b01)
         sel = 1'b0;
      else if (valid == 2'b10)
         sel = 1'b1;
      ready[0] = enable & valid[0] & ~sel;
      ready[1] = enable & valid[1] &  sel;
   end

endmodule

// File: rtl/char_plane_write_scheduler.sv
// char_plane_write_scheduler: shares the character plane write port between
// two character sources, interprets control codes, keeps the cursor and
// optionally runs a full-screen clear sweep.
// Build option: define CHAR_SCHED_CLEAR_EN to make form feed (0x0C) clear
// the whole plane; otherwise 0x0C is dropped like other control codes.
//
// Handshake: a character on requester i transfers on a rising clock edge
// where req_valid[i] & req_ready[i]; req_ready is combinational, only high
// in S_IDLE, and never high for both requesters at once. A source must hold
// req_valid and its req_char byte stable until the transfer happens.
module char_plane_write_scheduler
   import char_sched_pkg::*;
#(
   parameter int ROWS  = 16,
   parameter int COLS  = 64,
   parameter int ROW_W = 4,
   parameter int COL_W = 6
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [1:0]       req_valid,
   input  logic [15:0]      req_char,
   output logic [1:0]       req_ready,
   output logic             wr_en,
   output logic [ROW_W-1:0] wr_row,
   output logic [COL_W-1:0] wr_col,
   output logic [7:0]       wr_char,
   output logic [ROW_W-1:0] cur_row,
   output logic [COL_W-1:0] cur_col,
   output logic             busy,
   output logic [1:0]       state_dbg
);

   localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);
   localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);

   state_t           state;
   logic             last_grant;
   logic             sel;
   logic             xfer;
   logic [7:0]       in_char;
   logic [ROW_W-1:0] adv_row, lf_row, bs_row;
   logic [COL_W-1:0] adv_col, bs_col;

   rr_arbiter2 u_arb (
      .valid      (req_valid),
      .last_grant (last_grant),
      .enable     (state == S_IDLE),
      .ready      (req_ready),
      .sel        (sel)
   );

   assign xfer      = |(req_valid & req_ready);
   assign in_char   = sel ? req_char[15:8] : req_char[7:0];
   assign busy      = (state != S_IDLE);
   assign state_dbg = state;

   // Next cursor positions for advance, line feed and backspace.
   always_comb begin
      lf_row  = (cur_row == ROW_LAST) ? '0 : cur_row + 1'b1;
      adv_row = cur_row;
      adv_col = cur_col + 1'b1;
      if (cur_col == COL_LAST) begin
         adv_col = '0;
         adv_row = lf_row;
      end
      bs_row = cur_row;
      bs_col = cur_col - 1'b1;
      if (cur_col == '0) begin
         if (cur_row == '0) begin
            bs_col = '0;
         end else begin
            bs_row = cur_row - 1'b1;
            bs_col = COL_LAST;
         end
      end
   end

   // Control FSM with registered write port, cursor and arbitration history.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= S_IDLE;
         last_grant <= 1'b1;
         wr_en      <= 1'b0;
         wr_row     <= '0;
         wr_col     <= '0;
         wr_char    <= '0;
         cur_row    <= '0;
         cur_col    <= '0;
      end else begin
         wr_en <= 1'b0;
         case (state)
            S_IDLE: begin
               if (xfer) begin
                  last_grant <= sel;
                  if (is_printable(in_char)) begin
                     wr_en   <= 1'b1;
                     wr_row  <= cur_row;
                     wr_col  <= cur_col;
                     wr_char <= in_char;
                     cur_row <= adv_row;
                     cur_col <= adv_col;
                     state   <= S_WRITE;
                  end else if (in_char == CH_BS) begin
                     wr_en   <= 1'b1;
                     wr_row  <= bs_row;
                     wr_col  <= bs_col;
                     wr_char <= CH_SPACE;
                     cur_row <= bs_row;
                     cur_col <= bs_col;
                     state   <= S_WRITE;
                  end else if (in_char == CH_CR) begin
                     cur_col <= '0;
                  end else if (in_char == CH_LF) begin
                     cur_col <= '0;
                     cur_row <= lf_row;
`ifdef CHAR_SCHED_CLEAR_EN
                  end else if (in_char == CH_FF) begin
                     wr_en   <= 1'b1;
                     wr_row  <= '0;
                     wr_col  <= '0;
                     wr_char <= CH_SPACE;
                     state   <= S_CLEAR;
`endif
                  end
               end
            end
            S_WRITE: state <= S_IDLE;
`ifdef CHAR_SCHED_CLEAR_EN
            // The write address doubles as the sweep counter.
            S_CLEAR: begin
               if (wr_row == ROW_LAST && wr_col == COL_LAST) begin
                  cur_row <= '0;
                  cur_col <= '0;
                  state   <= S_IDLE;
               end else begin
                  wr_en <= 1'b1;
                  if (wr_col == COL_LAST) begin
                     wr_col <= '0;
                     wr_row <= wr_row + 1'b1;
                  end else begin
                     wr_col <= wr_col + 1'b1;
                  end
               end
            end
`endif
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_char_plane_write_scheduler.sv
// Testbench for char_plane_write_scheduler: directed vectors, expected plane
// writes and grants queued by the drivers, popped by an independent monitor.
module tb_char_plane_write_scheduler;

   logic        clk;
   logic        reset;
   logic [1:0]  req_valid;
   logic [15:0] req_char;
   logic [1:0]  req_ready;
   logic        wr_en;
   logic [3:0]  wr_row;
   logic [5:0]  wr_col;
   logic [7:0]  wr_char;
   logic [3:0]  cur_row;
   logic [5:0]  cur_col;
   logic        busy;
   logic [1:0]  state_dbg;

   logic [17:0] exp_q[$];
   logic        grant_q[$];
   int          n_cmp = 0;
   int          n_bad = 0;

   char_plane_write_scheduler dut (
      .clk       (clk),
      .reset     (reset),
      .req_valid (req_valid),
      .req_char  (req_char),
      .req_ready (req_ready),
      .wr_en     (wr_en),
      .wr_row    (wr_row),
      .wr_col    (wr_col),
      .wr_char   (wr_char),
      .cur_row   (cur_row),
      .cur_col   (cur_col),
      .busy      (busy),
      .state_dbg (state_dbg)
   );

   // clock and watchdog
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic push_wr(input int r, input int c, input logic [7:0] ch);
      exp_q.push_back({4'(r), 6'(c), ch});
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Offer one character on requester idx and hold it until it transfers.
   task automatic send(input int idx, input logic [7:0] ch);
      int n;
      n = 0;
      grant_q.push_back(idx[0]);
      if (idx == 0) req_char[7:0] = ch;
      else          req_char[15:8] = ch;
      req_valid[idx] = 1'b1;
      @(negedge clk);
      while (!req_ready[idx] && n < 100) begin
         n++;
         @(negedge clk);
      end
      if (n >= 100) begin
         n_cmp++;
         n_bad++;
         $display("FAIL send_timeout: req%0d char 0x%0h got no ready", idx, ch);
      end
      @(posedge clk);
      #1;
      req_valid[idx] = 1'b0;
   endtask

   task automatic chk_cursor(input string nm, input int r, input int c);
      chk({nm, "_row"}, 32'(cur_row), 32'(r));
      chk({nm, "_col"}, 32'(cur_col), 32'(c));
   endtask

   task automatic chk_all_zero(input string nm);
      chk({nm, "_wr_en"}, 32'(wr_en), 0);
      chk({nm, "_wr_addr"}, 32'({wr_row, wr_col}), 0);
      chk({nm, "_wr_char"}, 32'(wr_char), 0);
      chk({nm, "_cursor"}, 32'({cur_row, cur_col}), 0);
      chk({nm, "_busy"}, 32'(busy), 0);
      chk({nm, "_ready"}, 32'(req_ready), 0);
   endtask

   // scoreboard monitor: pops expected writes and grants as the DUT shows them
   initial begin
      logic [17:0] e;
      logic        g;
      forever begin
         @(negedge clk);
         if (wr_en) begin
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL unexpected_write: row %0d col %0d char 0x%0h", wr_row, wr_col, wr_char);
            end else begin
               e = exp_q.pop_front();
               chk("write", 32'({wr_row, wr_col, wr_char}), 32'(e));
            end
         end
         if (req_ready != 2'b00) begin
            if (grant_q.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL unexpected_ready: got 0x%0h expected none", req_ready);
            end else begin
               g = grant_q.pop_front();
               chk("grant", 32'(req_ready), g ? 32'h2 : 32'h1);
            end
         end
      end
   end

   // stimulus
   initial begin
      int n;
      int bad;
      reset     = 1'b0;
      req_valid = 2'b00;
      req_char  = 16'h0000;
      repeat (3) @(posedge clk);
      #1;
      chk_all_zero("reset");
      @(negedge clk);
      reset = 1'b1;
      step();

      // single printable character
      push_wr(0, 0, 8'h41);
      send(0, 8'h41);
      chk_cursor("t1_cursor", 0, 1);
      chk("t1_busy_write", 32'(busy), 1);
      step();
      chk("t1_busy_idle", 32'(busy), 0);

      // both requesters streaming; last grant was 0 so requester 1 goes first
      req_char = {8'h62, 8'h61};
      grant_q.push_back(1'b1); grant_q.push_back(1'b0);
      grant_q.push_back(1'b1); grant_q.push_back(1'b0);
      push_wr(0, 1, 8'h62); push_wr(0, 2, 8'h61);
      push_wr(0, 3, 8'h62); push_wr(0, 4, 8'h61);
      req_valid = 2'b11;
      for (int k = 0; k < 4; k++) begin
         n = 0;
         @(negedge clk);
         while (req_ready == 2'b00 && n < 50) begin
            n++;
            @(negedge clk);
         end
         if (k > 0) chk("rr_spacing", 32'(n), 1);
         @(posedge clk);
         #1;
      end
      req_valid = 2'b00;
      chk_cursor("t2_cursor", 0, 5);

      // fill row 0, then wrap at the last column
      for (int c = 5; c < 63; c++) begin
         push_wr(0, c, 8'h2E);
         send(c % 2, 8'h2E);
      end
      chk_cursor("t3_at_edge", 0, 63);
      push_wr(0, 63, 8'h5A);
      send(1, 8'h5A);
      chk_cursor("t3_after_z", 1, 0);
      for (int r = 0; r < 14; r++) send(0, 8'h0A);
      chk_cursor("t3_row15", 15, 0);
      chk("t3_lf_busy", 32'(busy), 0);
      send(1, 8'h0A);
      chk_cursor("t3_lf_wrap", 0, 0);
      push_wr(0, 0, 8'h78);
      send(0, 8'h78);
      chk_cursor("t3_x", 0, 1);
      send(1, 8'h0D);
      chk_cursor("t3_cr", 0, 0);

      // backspace at origin, at column 0 of a later row, and mid-row
      push_wr(0, 0, 8'h20);
      send(1, 8'h08);
      chk_cursor("t4_bs_origin", 0, 0);
      send(0, 8'h0A);
      send(0, 8'h0A);
      chk_cursor("t4_row2", 2, 0);
      push_wr(1, 63, 8'h20);
      send(0, 8'h08);
      chk_cursor("t4_bs_row_back", 1, 63);
      push_wr(1, 62, 8'h20);
      send(1, 8'h08);
      chk_cursor("t4_bs_mid", 1, 62);

      // control codes that are dropped
      send(0, 8'h07);
      chk("t6_bel_busy", 32'(busy), 0);
      chk_cursor("t6_bel", 1, 62);
      send(1, 8'h7F);
      chk("t6_del_busy", 32'(busy), 0);
      chk_cursor("t6_del", 1, 62);
`ifndef CHAR_SCHED_CLEAR_EN
      send(0, 8'h0C);
      chk("t6_ff_busy", 32'(busy), 0);
      chk_cursor("t6_ff", 1, 62);
`else
      // full clear sweep, with requester 1 waiting throughout
      for (int r = 0; r < 16; r++)
         for (int c = 0; c < 64; c++)
            push_wr(r, c, 8'h20);
      send(0, 8'h0C);
      req_char[15:8] = 8'h07;
      req_valid[1]   = 1'b1;
      grant_q.push_back(1'b1);
      bad = 0;
      for (int i = 0; i < 1024; i++) begin
         @(negedge clk);
         if (!(busy && wr_en && req_ready == 2'b00)) bad++;
      end
      chk("t5_sweep_cycles_bad", 32'(bad), 0);
      n = 0;
      @(negedge clk);
      while (!req_ready[1] && n < 10) begin
         n++;
         @(negedge clk);
      end
      chk("t5_ready_after_sweep", 32'(n), 0);
      @(posedge clk);
      #1;
      req_valid = 2'b00;
      chk_cursor("t5_cursor", 0, 0);
      chk("t5_busy_after", 32'(busy), 0);

      // abort a second sweep part way through
      send(0, 8'h0C);
      repeat (499) @(negedge clk);
      #2;
      reset = 1'b0;
      #1;
      chk_all_zero("t5_abort");
      exp_q.delete();
      @(negedge clk);
      reset = 1'b1;
      step();
      push_wr(0, 0, 8'h51);
      send(0, 8'h51);
      step();
`endif

      // reset during a character write clears everything at once
      send(1, 8'h51);
      #1;
      reset = 1'b0;
      #1;
      chk_all_zero("abort_write");
      @(negedge clk);
      reset = 1'b1;
      step();

      // after reset, a tie goes to requester 0
      req_char = {8'h62, 8'h61};
      grant_q.push_back(1'b0);
      push_wr(0, 0, 8'h61);
      req_valid = 2'b11;
      n = 0;
      @(negedge clk);
      while (req_ready == 2'b00 && n < 20) begin
         n++;
         @(negedge clk);
      end
      chk("tie_wait", 32'(n), 0);
      @(posedge clk);
      #1;
      req_valid = 2'b00;
      chk_cursor("tie_cursor", 0, 1);

      repeat (4) @(posedge clk);
      chk("write_queue_left", 32'(exp_q.size()), 0);
      chk("grant_queue_left", 32'(grant_q.size()), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
